// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one W-bit adder iterated over W cycles,
// unsigned or two's-complement operands selected per operation.
module mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   y,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] mcand, mplier;
  logic [PW-1:0]   acc;
  logic            neg;

  logic            accept, last;
  logic [WIDTH:0]  sum;
  logic [PW-1:0]   acc_nx;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Handshake: start is taken on any edge where busy=0 (IDLE or DONE); while
  // busy=1 start is ignored. done pulses for one cycle with y final.
  always_comb begin
    accept   = start && (state != CALC);
    last     = (state == CALC) && (cnt == CW'(1));
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = accept ? CALC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Signed operands are reduced to magnitudes; -2^(W-1) maps to 2^(W-1).
  always_comb begin
    mag_a  = (sgn && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
    mag_b  = (sgn && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
    sum    = {1'b0, acc[PW-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : WIDTH'(0))};
    acc_nx = {sum, acc[WIDTH-1:1]};
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      y      <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mcand  <= mag_a;
        mplier <= mag_b;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
        neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (state == CALC) begin
        acc    <= acc_nx;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (last) y <= neg ? (PW'(0) - acc_nx) : acc_nx;
      end
    end
  end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Parametrised sequential shift-add multiplier; next generation of the team's fixed 4x4 combinational array multiplier.
- Uses one W-bit adder, iterated over W cycles, instead of W-1 adder rows.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Uses a start/busy/done handshake so datapath controllers can issue multiplies and wait for results.

Parameters:
- WIDTH, 8, operand width W in bits (legal range 2..32). Product width is 2W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a multiply; accepted only when busy=0.
- sgn  input  1  mode, sampled with start: 0 = unsigned, 1 = two's-complement signed.
- a  input  WIDTH  multiplicand, sampled with start.
- b  input  WIDTH  multiplier, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse: y is valid and final.
- y  output  2*WIDTH  product; held until the next accepted start completes.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; busy=0, done=0, y=0.
  - Internal accumulator, counter, operand and sign registers are cleared.
  - Reset takes priority over all other inputs, including mid-CALC; the in-flight result is discarded and no done pulse is produced.
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1, done=0.
  - DONE: busy=0, done=1.
- Acceptance: start=1 in IDLE or DONE at edge T.
  - Registers a, b, sgn and sets cnt=W.
  - Next state is CALC.
  - start while busy=1 is ignored; latched operands are unaffected.
- Sign handling at acceptance:
  - sgn=1: magnitudes |a| and |b| are registered as W-bit unsigned values; neg = a[W-1] XOR b[W-1].
  - -2^(W-1) has magnitude 2^(W-1), which fits in W unsigned bits.
  - sgn=0: raw a and b are used; neg=0.
- CALC, one step per cycle, W cycles total:
  - If the multiplier LSB is 1, add the multiplicand into the upper W+1 bits of the accumulator.
  - Shift the accumulator and multiplier right by one; decrement cnt.
  - When cnt reaches 0 after the step, the next state is DONE.
- Final result:
  - The final magnitude is 2W bits.
  - If neg=1, y = two's complement (0 - magnitude) mod 2^(2W); otherwise y = magnitude.
  - y is written on the edge entering DONE.
- Latency: start accepted at edge T → CALC for edges T+1..T+W → done=1 and y valid in the cycle following edge T+W, i.e. W+1 cycles after acceptance.
- DONE lasts exactly one cycle:
  - If start=1 in DONE: accept it (back-to-back throughput of one result per W+1 cycles) and go to CALC.
  - Otherwise go to IDLE.
- y persistence: y holds its value in IDLE and through a subsequent CALC; it changes only on entry to DONE or on reset.
- Zero operands get no early termination; latency is always W+1.
- Signed extremes: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) must be exact; there is no overflow in 2W bits.
- y is purely registered; there are no combinational paths from inputs to outputs.

Test Plan:
- W=4, sgn=0, a=15, b=15, start for 1 cycle → busy high 4 cycles; done pulse in the 5th cycle after acceptance; y=0xE1 (225); y still 0xE1 5 cycles later.
- W=8, sgn=1, a=0x80 (-128), b=0x07 → y=0xFC80 (-896). Then a=0x80, b=0x80 → y=0x4000. Then a=0xFF, b=0xFF → y=0x0001.
- W=8, sgn=0, a=0xFF, b=0xFF → y=0xFE01. Then a=0, b=0x5A → y=0 after the full 9-cycle latency.
- W=8: accept 3*5; pulse start with a=9, b=9 on CALC cycles 2 and 5 → ignored; y=15 at done; exactly one done pulse.
- W=8: accept 12*12; assert rst on CALC cycle 4 → next cycle busy=0, done=0, y=0; no done pulse appears within the following 12 cycles.
- W=8: hold start=1 with a=2, b=3, then switch to a=4, b=5 on the done cycle → done pulses 9 cycles apart with y=6 then y=20; busy is low only in the done cycle.
